axis_preamble_insert: RTL and testbench



---
 rtl/axis_preamble_insert.sv | 149 ++++++++++++++
 tb/tb_axis_preamble_insert.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_preamble_insert.sv
// Inserts a fixed PRE_LEN-symbol preamble in front of every tfirst-marked frame
// on a tvalid/tnext symbol stream; symbols before the first frame marker are dropped.
module axis_preamble_insert #(
    parameter int                    M        = 5,
    parameter int                    PRE_LEN  = 4,
    parameter logic [PRE_LEN*M-1:0]  PREAMBLE = 20'hF82AA,
    parameter int                    CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M-1:0]     s_axis_tdata,
    input  logic             s_axis_tfirst,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tnext,
    output logic [M-1:0]     m_axis_tdata,
    output logic             m_axis_tfirst,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tnext,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int IDX_W = $clog2(PRE_LEN + 1);

    typedef enum logic [1:0] {HUNT, PRE, HEAD, PASS} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               start_s;
    logic               m_xfer_s;

    // Preamble symbol i, taken MSB-first from the packed constant.
    function automatic logic [M-1:0] pre_sym(input logic [IDX_W-1:0] i);
        logic [PRE_LEN*M-1:0] sh;
        sh = PREAMBLE << (int'(i) * M);
        return sh[PRE_LEN*M-1 -: M];
    endfunction

    // Handshake and data outputs; pass-through states are purely combinational.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tfirst = 1'b0;
        m_axis_tdata  = s_axis_tdata;
        s_axis_tnext  = 1'b0;
        start_s       = 1'b0;
        if (rst) begin
            m_axis_tvalid = 1'b0;
            s_axis_tnext  = 1'b0;
        end else begin
            case (state_q)
                HUNT, PASS: begin
                    if (s_axis_tvalid && s_axis_tfirst) begin
                        // The frame's first symbol stays held upstream until the preamble is out.
                        start_s       = 1'b1;
                        m_axis_tvalid = 1'b1;
                        m_axis_tfirst = 1'b1;
                        m_axis_tdata  = pre_sym('0);
                    end else if (state_q == PASS) begin
                        m_axis_tvalid = s_axis_tvalid;
                        s_axis_tnext  = m_axis_tnext & s_axis_tvalid;
                    end else begin
                        s_axis_tnext  = s_axis_tvalid;
                    end
                end
                PRE: begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = pre_sym(idx_q);
                end
                HEAD: begin
                    m_axis_tvalid = s_axis_tvalid;
                    s_axis_tnext  = m_axis_tnext & s_axis_tvalid;
                end
                default: begin
                    m_axis_tvalid = 1'b0;
                end
            endcase
        end
    end

    assign m_xfer_s = m_axis_tvalid & m_axis_tnext;

    // Next-state, preamble index and statistics counters.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        drop_d  = drop_q;
        case (state_q)
            HUNT, PASS: begin
                if (start_s) begin
                    if (m_xfer_s) begin
                        frame_d = frame_q + CNT_W'(1);
                        idx_d   = IDX_W'(1);
                        state_d = (PRE_LEN > 1) ? PRE : HEAD;
                    end else begin
                        state_d = state_q;
                    end
                end else if (state_q == HUNT && s_axis_tvalid) begin
                    drop_d = drop_q + CNT_W'(1);
                end else begin
                    drop_d = drop_q;
                end
            end
            PRE: begin
                if (m_xfer_s) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(PRE_LEN - 1)) begin
                        state_d = HEAD;
                    end else begin
                        state_d = PRE;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            HEAD: begin
                if (m_xfer_s) begin
                    state_d = PASS;
                end else begin
                    state_d = HEAD;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            idx_q   <= '0;
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            drop_q  <= drop_d;
        end
    end

    assign frame_count = frame_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_axis_preamble_insert.sv
// Directed and randomised-stall checks of axis_preamble_insert with FWFT-style sources.
module tb_axis_preamble_insert;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;

    logic [4:0]  s_tdata0, s_tdata1, m_tdata0, m_tdata1;
    logic        s_tfirst0, s_tfirst1, s_tvalid0, s_tvalid1, s_tnext0, s_tnext1;
    logic        m_tfirst0, m_tfirst1, m_tvalid0, m_tvalid1;
    logic        m_tnext0 = 1'b0, m_tnext1 = 1'b0;
    logic [15:0] fc0, dc0, fc1, dc1;

    logic [5:0]  fifo0[$], fifo1[$], out0[$], out1[$], exp0[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    axis_preamble_insert dut0 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata0), .s_axis_tfirst(s_tfirst0), .s_axis_tvalid(s_tvalid0),
        .s_axis_tnext(s_tnext0),
        .m_axis_tdata(m_tdata0), .m_axis_tfirst(m_tfirst0), .m_axis_tvalid(m_tvalid0),
        .m_axis_tnext(m_tnext0),
        .frame_count(fc0), .drop_count(dc0)
    );

    axis_preamble_insert #(.PRE_LEN(1), .PREAMBLE(5'h1B)) dut1 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata1), .s_axis_tfirst(s_tfirst1), .s_axis_tvalid(s_tvalid1),
        .s_axis_tnext(s_tnext1),
        .m_axis_tdata(m_tdata1), .m_axis_tfirst(m_tfirst1), .m_axis_tvalid(m_tvalid1),
        .m_axis_tnext(m_tnext1),
        .frame_count(fc1), .drop_count(dc1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present FIFO heads to the DUTs, then a sink strobe only while valid.
    task automatic drive();
        logic [5:0] h;
        s_tvalid0 = (fifo0.size() != 0);
        h = s_tvalid0 ? fifo0[0] : 6'h00;
        s_tfirst0 = h[5];
        s_tdata0  = h[4:0];
        s_tvalid1 = (fifo1.size() != 0);
        h = s_tvalid1 ? fifo1[0] : 6'h00;
        s_tfirst1 = h[5];
        s_tdata1  = h[4:0];
        #1;
        m_tnext0 = rdy & m_tvalid0;
        m_tnext1 = rdy & m_tvalid1;
    endtask

    task automatic step();
        logic sx0, sx1;
        @(negedge clk);
        if (m_tvalid0 && m_tnext0) out0.push_back({m_tfirst0, m_tdata0});
        if (m_tvalid1 && m_tnext1) out1.push_back({m_tfirst1, m_tdata1});
        sx0 = s_tvalid0 & s_tnext0;
        sx1 = s_tvalid1 & s_tnext1;
        @(posedge clk);
        #1;
        if (sx0) void'(fifo0.pop_front());
        if (sx1) void'(fifo1.pop_front());
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive();
        step();
        rst = 1'b0;
        drive();
        out0.delete();
        out1.delete();
    endtask

    task automatic drain(input string tag, input int bound);
        int cnt = 0;
        while ((fifo0.size() != 0 || fifo1.size() != 0) && cnt < bound) begin
            step();
            cnt++;
        end
        check({tag, "_timeout"}, (cnt >= bound) ? 32'd1 : 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic cmp_out0(input string tag);
        check({tag, "_len"}, out0.size(), exp0.size());
        for (int i = 0; i < out0.size() && i < exp0.size(); i++)
            check($sformatf("%s_sym%0d", tag, i), out0[i], exp0[i]);
    endtask

    initial begin
        int hunt_m, drops_m, frames_m;
        logic [5:0] sym;

        fifo0.delete();
        fifo1.delete();
        drive();
        step();
        check("rst_tvalid", m_tvalid0, 1'b0);
        check("rst_tnext", s_tnext0, 1'b0);
        do_reset();
        check("reset_frame_count", fc0, 16'd0);
        check("reset_drop_count", dc0, 16'd0);
        check("reset_tvalid", m_tvalid0, 1'b0);

        // Basic frame: exactly 7 transfers in 7 cycles with the sink always ready.
        fifo0 = '{6'h23, 6'h04, 6'h05};
        drive();
        for (int i = 0; i < 7; i++) step();
        check("basic_7cycles", out0.size(), 32'd7);
        drain("basic", 50);
        exp0 = '{6'h3F, 6'h00, 6'h15, 6'h0A, 6'h03, 6'h04, 6'h05};
        cmp_out0("basic");
        check("basic_frame_count", fc0, 16'd1);

        // Hunt drop.
        do_reset();
        fifo0 = '{6'h11, 6'h12, 6'h27};
        drive();
        drain("hunt", 50);
        exp0 = '{6'h3F, 6'h00, 6'h15, 6'h0A, 6'h07};
        cmp_out0("hunt");
        check("hunt_drop_count", dc0, 16'd2);
        check("hunt_frame_count", fc0, 16'd1);

        // Back-to-back single-symbol frames.
        do_reset();
        fifo0 = '{6'h21, 6'h22};
        drive();
        drain("b2b", 50);
        exp0 = '{6'h3F, 6'h00, 6'h15, 6'h0A, 6'h01, 6'h3F, 6'h00, 6'h15, 6'h0A, 6'h02};
        cmp_out0("b2b");
        check("b2b_frame_count", fc0, 16'd2);

        // Reset after two preamble symbols were accepted.
        do_reset();
        fifo0 = '{6'h2A, 6'h0B};
        drive();
        step();
        step();
        check("midrst_pre_len", out0.size(), 32'd2);
        rst = 1'b1;
        drive();
        check("midrst_tvalid", m_tvalid0, 1'b0);
        check("midrst_tnext", s_tnext0, 1'b0);
        step();
        rst = 1'b0;
        drive();
        check("midrst_frame_count", fc0, 16'd0);
        check("midrst_drop_count", dc0, 16'd0);
        check("midrst_restart", {m_tvalid0, m_tfirst0, m_tdata0}, {2'b11, 5'h1F});
        drain("midrst", 50);
        exp0 = '{6'h3F, 6'h00, 6'h3F, 6'h00, 6'h15, 6'h0A, 6'h0A, 6'h0B};
        cmp_out0("midrst");
        check("midrst_frame_after", fc0, 16'd1);

        // Single-symbol preamble instance.
        do_reset();
        fifo1 = '{6'h29, 6'h2C, 6'h0D};
        drive();
        drain("pre1", 50);
        check("pre1_len", out1.size(), 32'd5);
        if (out1.size() == 5) begin
            check("pre1_s0", out1[0], 6'h3B);
            check("pre1_s1", out1[1], 6'h09);
            check("pre1_s2", out1[2], 6'h3B);
            check("pre1_s3", out1[3], 6'h0C);
            check("pre1_s4", out1[4], 6'h0D);
        end
        check("pre1_frame_count", fc1, 16'd2);

        // Random sink stalls against a stream-level model.
        do_reset();
        exp0.delete();
        hunt_m = 1;
        drops_m = 0;
        frames_m = 0;
        for (int i = 0; i < 1024; i++) begin
            sym[4:0] = 5'($urandom_range(0, 31));
            sym[5]   = (i >= 2) && ($urandom_range(0, 10) == 0);
            fifo0.push_back(sym);
            if (sym[5]) begin
                exp0.push_back(6'h3F);
                exp0.push_back(6'h00);
                exp0.push_back(6'h15);
                exp0.push_back(6'h0A);
                exp0.push_back({1'b0, sym[4:0]});
                hunt_m = 0;
                frames_m++;
            end else if (hunt_m != 0) begin
                drops_m++;
            end else begin
                exp0.push_back(sym);
            end
        end
        drive();
        for (int i = 0; i < 20000 && fifo0.size() != 0; i++) begin
            rdy = 1'($urandom_range(0, 1));
            step();
        end
        rdy = 1'b1;
        drain("rand", 100);
        cmp_out0("rand");
        check("rand_frame_count", fc0, 32'(frames_m));
        check("rand_drop_count", dc0, 32'(drops_m));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
